ll_sc_unit: RTL
===============

# ll_sc_unit

Per-core load-linked / store-conditional reservation unit between the datapath's data-memory port and the L1 dcache. It services the `datomic` qualifier the control unit raises on `ll` (with `dREN`) and `sc` (with `dWEN`). It holds the link register, watches local stores and coherence snoops that break the reservation, and either forwards an access to the dcache or answers a failed `sc` locally with 0. Ordinary loads and stores pass through the same handshake unchanged.

## Interface
- `BLK_OFF`, default 3: low address bits ignored for link matching (block offset + byte offset; two-word blocks).
- `CNT_W`, default 16: width of the saturating `sc` failure counter.
- `CLK`, in, 1: clock.
- `RST`, in, 1: reset. Single clock; reset is asynchronous and active-high.
- `dmemREN`, in, 1: datapath read request (`lw`/`ll`).
- `dmemWEN`, in, 1: datapath write request (`sw`/`sc`).
- `datomic`, in, 1: request is `ll` (with REN) or `sc` (with WEN).
- `dmemaddr`, in, 32: byte address.
- `dmemstore`, in, 32: store data.
- `dhit`, out, 1: request complete, one-cycle pulse.
- `dmemload`, out, 32: load data, or the `sc` result (1 or 0) when `dhit` is high.
- `c_ren`, out, 1: dcache read request.
- `c_wen`, out, 1: dcache write request.
- `c_addr`, out, 32: dcache address.
- `c_store`, out, 32: dcache store data.
- `c_hit`, in, 1: dcache access complete.
- `c_load`, in, 32: dcache read data.
- `snoop_inv`, in, 1: coherence invalidate or remote write observed this cycle.
- `snoop_addr`, in, 32: address of the snoop.
- `halt`, in, 1: core halted; clears the link.
- `sc_fail_cnt`, out, `CNT_W`: saturating count of failed `sc`.

## Operation
- **State:** `link_valid`, `link_addr[31:BLK_OFF]`, FSM {IDLE, ACCESS, FAIL}, `sc_fail_cnt`.
- **Request types:**
  - `req` = `dmemREN | dmemWEN`.
  - `is_ll` = `dmemREN & datomic`.
  - `is_sc` = `dmemWEN & datomic`.
- **Block match:** `lmatch(a)` = `link_valid & (a[31:BLK_OFF] == link_addr)`.
- **IDLE:**
  - `is_sc` and not `lmatch(dmemaddr)` → FAIL.
  - Otherwise, on `req` → ACCESS.
  - No `req` → stay in IDLE.
- **ACCESS:**
  - `c_addr = dmemaddr`, `c_store = dmemstore`, `c_ren = dmemREN`.
  - `c_wen = dmemWEN & ~(is_sc & snoop_inv & snoop_addr[31:BLK_OFF]==link_addr)`.
  - Snoop hits the linked block while an `sc` is in ACCESS: clear `link_valid`, deassert `c_wen` the same cycle, go to FAIL next cycle. This holds even if `c_hit` is high that cycle; the write is suppressed.
  - On `c_hit` without abort: pulse `dhit` and return to IDLE.
    - `dmemload = c_load` for loads.
    - `dmemload = 32'd1` for a successful `sc`.
- **FAIL:** `dhit=1`, `dmemload=0`, no cache request; increment `sc_fail_cnt` (saturate at all-ones); → IDLE.
- **Link updates, applied at the cycle a request completes:**
  - `ll` hit sets `link_valid=1` and `link_addr=dmemaddr[31:BLK_OFF]`.
  - `sc` success clears the link.
  - Ordinary `sw` hit with `lmatch` clears the link.
  - `sw` to another block leaves the link.
- **Snoop outside an SC access:** `snoop_inv` matching the link in any state clears `link_valid`.
  - If the snoop coincides with an `ll` completing, the `ll` set wins, since it is the newer reservation: the `ll` data arrived after the cache resolved the snoop.
- **`halt`:** clears `link_valid`. Any in-flight access still completes.
- **Cache outputs outside ACCESS:** all zero.

## Timing
- Reset: state IDLE, `link_valid=0`, `link_addr=0`, `sc_fail_cnt=0`. All outputs 0 (`dhit`, `dmemload`, `c_ren`, `c_wen`, `c_addr`, `c_store`).
- Latency:
  - Forwarded access: 1 cycle in IDLE, then ACCESS until `c_hit`. `dhit` is asserted in the `c_hit` cycle, so the minimum is 2 cycles.
  - Failed-in-IDLE `sc`: `dhit` exactly 2 cycles after the request is presented.
- The datapath holds `dmemREN`/`dmemWEN`/`datomic`/`dmemaddr`/`dmemstore` stable until `dhit`. The cycle after `dhit` is IDLE, and a new request is accepted there.
- `dhit` is never high for two consecutive cycles.
- `RST` mid-ACCESS: immediate return to IDLE with link cleared; the dcache sees its request drop asynchronously.
- Link and counter registers update on the `CLK` rising edge.

## Structure
- `cpu_types_pkg` receives:
  - `typedef enum logic [1:0] {LS_IDLE, LS_ACCESS, LS_FAIL} llsc_state_t`
  - the existing `word_t` for the 32-bit buses.
- One sub-module, `llsc_link_reg`, holds `link_valid`/`link_addr`: set, clear and match logic, including the snoop/ll priority rule. The FSM and counter stay in `ll_sc_unit`.
- Instantiated once per core inside the dcache wrapper.

## Test plan
- **Successful pair:** `ll` 0x100 (`c_load`=0xAB, hit after 3 cycles) returns `dmemload`=0xAB and sets the link. Then `sc` 0x104 data 0x5 → `c_wen` asserted, `dmemload`=1, link cleared.
- **Remote write breaks the link:** `ll` 0x200, then `snoop_inv` with `snoop_addr`=0x204, then `sc` 0x200 → no `c_wen` ever; `dhit` 2 cycles after the request with `dmemload`=0; `sc_fail_cnt`=1.
- **Snoop during SC:** `ll` 0x300, `sc` 0x300 enters ACCESS, `snoop_inv` to 0x300 in the same cycle as `c_hit` → `c_wen` low that cycle, FAIL next, `dmemload`=0.
- **Local store:** `ll` 0x400, `sw` 0x404 clears the link → `sc` 0x400 fails. Separately, `ll` 0x400, `sw` 0x500, `sc` 0x400 succeeds.
- **Reset and saturation:**
  - Assert `RST` mid-ACCESS of an `ll` → all outputs 0 immediately; a following `sc` fails.
  - 65 536 failures → `sc_fail_cnt` holds 0xFFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: bus word and the LL/SC reservation FSM states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        LS_IDLE,
        LS_ACCESS,
        LS_FAIL
    } llsc_state_t;

endpackage

// File: rtl/llsc_link_reg.sv
// Link register for LL/SC: reservation valid bit plus the linked block address.
// Owns the set/clear priority and the block-match comparators.
module llsc_link_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned BLK_OFF = 3
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  set_i,        // ll completing this cycle
    input  word_t set_addr_i,
    input  logic  clr_i,        // sc success or sw to the linked block
    input  logic  halt_i,
    input  logic  snoop_inv_i,
    input  word_t snoop_addr_i,
    input  word_t match_addr_i,
    output logic  match_o,      // match_addr_i falls in a valid linked block
    output logic  snoop_blk_o   // snoop block equals linked block (valid not considered)
);

    logic              link_valid_q, link_valid_d;
    logic [31:BLK_OFF] link_addr_q, link_addr_d;

    // Offset bits never take part in block matching.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{set_addr_i[BLK_OFF-1:0], snoop_addr_i[BLK_OFF-1:0],
                                  match_addr_i[BLK_OFF-1:0]};

    assign snoop_blk_o = (snoop_addr_i[31:BLK_OFF] == link_addr_q);
    assign match_o     = link_valid_q & (match_addr_i[31:BLK_OFF] == link_addr_q);

    // Next link state: halt beats everything; a completing ll beats a coincident
    // snoop because its data arrived after the cache resolved that snoop.
    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (halt_i) begin
            link_valid_d = 1'b0;
        end else if (set_i) begin
            link_valid_d = 1'b1;
            link_addr_d  = set_addr_i[31:BLK_OFF];
        end else if (clr_i || (snoop_inv_i && snoop_blk_o)) begin
            link_valid_d = 1'b0;
        end
    end

    // Link state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

endmodule

// File: rtl/ll_sc_unit.sv
// Per-core LL/SC reservation unit between the datapath memory port and the dcache.
// Forwards accesses to the dcache, answers doomed sc locally with 0, and counts
// failed sc in a saturating counter.
module ll_sc_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned BLK_OFF = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             dmemREN,
    input  logic             dmemWEN,
    input  logic             datomic,
    input  word_t            dmemaddr,
    input  word_t            dmemstore,
    output logic             dhit,
    output word_t            dmemload,
    output logic             c_ren,
    output logic             c_wen,
    output word_t            c_addr,
    output word_t            c_store,
    input  logic             c_hit,
    input  word_t            c_load,
    input  logic             snoop_inv,
    input  word_t            snoop_addr,
    input  logic             halt,
    output logic [CNT_W-1:0] sc_fail_cnt
);

    llsc_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic req, is_ll, is_sc;
    logic lmatch, snoop_blk;
    logic abort, done;
    logic link_set, link_clr;

    assign req   = dmemREN | dmemWEN;
    assign is_ll = dmemREN & datomic;
    assign is_sc = dmemWEN & datomic;

    // An sc in flight loses its reservation to a snoop on the linked block; the
    // write is dropped even if the cache reports a hit in that same cycle.
    assign abort = (state_q == LS_ACCESS) & is_sc & snoop_inv & snoop_blk;
    assign done  = (state_q == LS_ACCESS) & c_hit & ~abort;

    assign link_set = done & is_ll;
    assign link_clr = done & dmemWEN & (is_sc | lmatch);

    llsc_link_reg #(
        .BLK_OFF (BLK_OFF)
    ) u_link (
        .clk_i        (CLK),
        .rst_i        (RST),
        .set_i        (link_set),
        .set_addr_i   (dmemaddr),
        .clr_i        (link_clr),
        .halt_i       (halt),
        .snoop_inv_i  (snoop_inv),
        .snoop_addr_i (snoop_addr),
        .match_addr_i (dmemaddr),
        .match_o      (lmatch),
        .snoop_blk_o  (snoop_blk)
    );

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LS_IDLE: begin
                if (is_sc && !lmatch) begin
                    state_d = LS_FAIL;
                end else if (req) begin
                    state_d = LS_ACCESS;
                end
            end
            LS_ACCESS: begin
                if (abort) begin
                    state_d = LS_FAIL;
                end else if (c_hit) begin
                    state_d = LS_IDLE;
                end
            end
            LS_FAIL: state_d = LS_IDLE;
            default: state_d = LS_IDLE;
        endcase
    end

    // Failure counter: one increment per FAIL cycle, sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == LS_FAIL) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath and cache outputs; everything is zero outside ACCESS/FAIL so a
    // reset drops the cache request without waiting for a clock.
    always_comb begin
        dhit     = 1'b0;
        dmemload = '0;
        c_ren    = 1'b0;
        c_wen    = 1'b0;
        c_addr   = '0;
        c_store  = '0;
        unique case (state_q)
            LS_ACCESS: begin
                c_ren   = dmemREN;
                c_wen   = dmemWEN & ~abort;
                c_addr  = dmemaddr;
                c_store = dmemstore;
                if (done) begin
                    dhit = 1'b1;
                    if (is_sc) begin
                        dmemload = 32'd1;
                    end else if (dmemREN) begin
                        dmemload = c_load;
                    end
                end
            end
            LS_FAIL: begin
                dhit     = 1'b1;
                dmemload = '0;
            end
            default: begin
                dhit = 1'b0;
            end
        endcase
    end

    // FSM state and failure counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= LS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sc_fail_cnt = cnt_q;

endmodule
